// File: rtl/ssd1331_spi_pkg.sv
// Shared types and helpers for the SSD1331 SPI transmit arbiter slice.
package ssd1331_spi_pkg;

  localparam int LEN_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_GAP
  } tx_state_t;

  // cap must be representable in LEN_W bits (buffer depth of at most 31)
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned      cap);
    logic [LEN_W-1:0] cap_w;
    cap_w = LEN_W'(cap);
    return (len > cap_w) ? cap_w : len;
  endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter: registered favour pointer, combinational grant.
module spi_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       valid,
  output logic       idx
);

  logic favour;

  always_comb begin
    valid = |req;
    idx   = 1'b0;
    if (req == 2'b11) begin
      idx = favour;
    end else begin
      idx = req[1];
    end
  end

  // After a grant, the other requester is favoured on the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      favour <= 1'b0;
    end else if (advance && valid) begin
      favour <= ~idx;
    end
  end

endmodule

// File: rtl/ssd1331_spi_tx_arbiter.sv
// Shares one SPI MOSI buffer between an init sequencer (A) and a draw engine (B),
// with a CS-high gap after every packet and a watchdog on stuck transfers.
module ssd1331_spi_tx_arbiter
  import ssd1331_spi_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int N          = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic               i_SCK,
  input  logic               i_RST,
  input  logic               i_REQ_A,
  input  logic [WIDTH*N-1:0] i_DATA_A,
  input  logic [N-1:0]       i_DC_A,
  input  logic [LEN_W-1:0]   i_LEN_A,
  output logic               o_ACK_A,
  output logic               o_DONE_A,
  input  logic               i_REQ_B,
  input  logic [WIDTH*N-1:0] i_DATA_B,
  input  logic [N-1:0]       i_DC_B,
  input  logic [LEN_W-1:0]   i_LEN_B,
  output logic               o_ACK_B,
  output logic               o_DONE_B,
  output logic [WIDTH*N-1:0] o_BUF_DATA,
  output logic [N-1:0]       o_BUF_DC,
  output logic [LEN_W-1:0]   o_BUF_N,
  output logic               o_BUF_START,
  input  logic               i_BUF_FINAL_BYTE,
  output logic               o_GRANT,
  output logic               o_BUSY,
  output logic               o_ERR
);

  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_t        state;
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             arb_valid;
  logic             arb_idx;

  spi_rr_arb2 u_arb (
    .clk     (i_SCK),
    .rst     (i_RST),
    .req     ({i_REQ_B, i_REQ_A}),
    .advance (state == ST_IDLE),
    .valid   (arb_valid),
    .idx     (arb_idx)
  );

  always_ff @(posedge i_SCK) begin
    if (i_RST) begin
      state       <= ST_IDLE;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      o_ACK_A     <= 1'b0;
      o_ACK_B     <= 1'b0;
      o_DONE_A    <= 1'b0;
      o_DONE_B    <= 1'b0;
      o_BUF_DATA  <= '0;
      o_BUF_DC    <= '0;
      o_BUF_N     <= '0;
      o_BUF_START <= 1'b0;
      o_GRANT     <= 1'b0;
      o_BUSY      <= 1'b0;
      o_ERR       <= 1'b0;
    end else begin
      o_ACK_A     <= 1'b0;
      o_ACK_B     <= 1'b0;
      o_DONE_A    <= 1'b0;
      o_DONE_B    <= 1'b0;
      o_BUF_START <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The latch and ACK happen on this edge, so ACK is visible during LOAD.
          if (arb_valid) begin
            o_GRANT <= arb_idx;
            o_BUSY  <= 1'b1;
            if (arb_idx) begin
              o_BUF_DATA <= i_DATA_B;
              o_BUF_DC   <= i_DC_B;
              o_BUF_N    <= clamp_len(i_LEN_B, N);
              o_ACK_B    <= 1'b1;
            end else begin
              o_BUF_DATA <= i_DATA_A;
              o_BUF_DC   <= i_DC_A;
              o_BUF_N    <= clamp_len(i_LEN_A, N);
              o_ACK_A    <= 1'b1;
            end
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (o_BUF_N == '0) begin
            o_DONE_A <= ~o_GRANT;
            o_DONE_B <= o_GRANT;
            gap_cnt  <= '0;
            state    <= ST_GAP;
          end else begin
            o_BUF_START <= 1'b1;
            state       <= ST_START;
          end
        end
        ST_START: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_BUF_FINAL_BYTE || (wd_cnt == WD_W'(TIMEOUT - 1))) begin
            o_ERR    <= o_ERR | ~i_BUF_FINAL_BYTE;
            o_DONE_A <= ~o_GRANT;
            o_DONE_B <= o_GRANT;
            gap_cnt  <= '0;
            state    <= ST_GAP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          // The DONE cycle is not counted as CS-high time, hence GAP_CYCLES+1 cycles here.
          if (gap_cnt == GAP_W'(GAP_CYCLES)) begin
            o_BUSY <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          o_BUSY <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1331_spi_tx_arbiter.sv
// Directed scoreboard bench for ssd1331_spi_tx_arbiter with a simple buffer stub.
module tb_ssd1331_spi_tx_arbiter;

  localparam int WIDTH      = 8;
  localparam int N          = 8;
  localparam int GAP_CYCLES = 4;
  localparam int TIMEOUT    = 1024;
  localparam int DW         = WIDTH * N;

  typedef struct {
    logic          owner;
    logic [4:0]    n;
    logic [DW-1:0] data;
    logic [N-1:0]  dc;
    logic          err;
  } pkt_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, req_b;
  logic [DW-1:0] data_a, data_b;
  logic [N-1:0]  dc_a, dc_b;
  logic [4:0]    len_a, len_b;
  logic          ack_a, ack_b, done_a, done_b;
  logic [DW-1:0] buf_data;
  logic [N-1:0]  buf_dc;
  logic [4:0]    buf_n;
  logic          buf_start;
  logic          final_byte;
  logic          grant, busy, err;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   acks = 0, dones = 0, starts = 0, ack_b_count = 0;
  int   last_ack_cycle = 0, last_done_cycle = 0, last_start_cycle = 0, last_final_cycle = 0;
  logic model_err = 1'b0;
  logic stub_en = 1'b1;
  pkt_t exp_q[$];
  pkt_t done_q[$];

  ssd1331_spi_tx_arbiter #(
    .WIDTH(WIDTH), .N(N), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_SCK(clk), .i_RST(rst),
    .i_REQ_A(req_a), .i_DATA_A(data_a), .i_DC_A(dc_a), .i_LEN_A(len_a),
    .o_ACK_A(ack_a), .o_DONE_A(done_a),
    .i_REQ_B(req_b), .i_DATA_B(data_b), .i_DC_B(dc_b), .i_LEN_B(len_b),
    .o_ACK_B(ack_b), .o_DONE_B(done_b),
    .o_BUF_DATA(buf_data), .o_BUF_DC(buf_dc), .o_BUF_N(buf_n), .o_BUF_START(buf_start),
    .i_BUF_FINAL_BYTE(final_byte),
    .o_GRANT(grant), .o_BUSY(busy), .o_ERR(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Buffer stub: raises FINAL_BYTE for one cycle, 2*N_transmit cycles after START.
  int stub_cnt = 0;
  logic stub_busy = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      stub_busy  <= 1'b0;
      stub_cnt   <= 0;
      final_byte <= 1'b0;
    end else begin
      final_byte <= 1'b0;
      if (buf_start && stub_en) begin
        stub_busy <= 1'b1;
        stub_cnt  <= 2 * int'(buf_n);
      end else if (stub_busy) begin
        if (stub_cnt <= 1) begin
          final_byte <= 1'b1;
          stub_busy  <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectPacket(input logic owner, input logic [DW-1:0] data,
                              input logic [N-1:0] dc, input logic [4:0] len);
    pkt_t p;
    p.owner = owner;
    p.n     = (len > 5'(N)) ? 5'(N) : len;
    p.data  = data;
    p.dc    = dc;
    p.err   = model_err;
    exp_q.push_back(p);
  endtask

  task automatic applyStimulus(input logic sel, input logic [DW-1:0] data,
                               input logic [N-1:0] dc, input logic [4:0] len);
    if (sel) begin
      data_b = data; dc_b = dc; len_b = len; req_b = 1'b1;
    end else begin
      data_a = data; dc_a = dc; len_a = len; req_a = 1'b1;
    end
    expectPacket(sel, data, dc, len);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitAcks(input int target, input int limit, input string tag);
    int n = 0;
    while (acks < target && n < limit) begin
      @(posedge clk); #2; n++;
    end
    checkOutput({tag, "_ack_seen"}, 64'(acks >= target), 64'd1);
  endtask

  task automatic waitDones(input int target, input int limit, input string tag);
    int n = 0;
    while (dones < target && n < limit) begin
      @(posedge clk); #2; n++;
    end
    checkOutput({tag, "_done_seen"}, 64'(dones >= target), 64'd1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
    checkOutput({tag, "_grant"}, 64'(grant), 64'd0);
    checkOutput({tag, "_buf_n"}, 64'(buf_n), 64'd0);
    checkOutput({tag, "_buf_data"}, buf_data, 64'd0);
    checkOutput({tag, "_buf_dc"}, 64'(buf_dc), 64'd0);
    checkOutput({tag, "_buf_start"}, 64'(buf_start), 64'd0);
    checkOutput({tag, "_ack_done"}, 64'({ack_a, ack_b, done_a, done_b}), 64'd0);
  endtask

  // Scoreboard: ACKs pop the expected packet, DONEs pop the in-flight packet.
  always @(negedge clk) begin
    pkt_t e;
    if (!rst) begin
      if (buf_start) begin
        starts++;
        last_start_cycle = cycle;
      end
      if (final_byte) last_final_cycle = cycle;
      if (ack_a || ack_b) begin
        if (ack_b) ack_b_count++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_ack", 64'({ack_a, ack_b}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("ack_owner", 64'({ack_a, ack_b}), e.owner ? 64'd1 : 64'd2);
          checkOutput("grant", 64'(grant), 64'(e.owner));
          checkOutput("buf_n", 64'(buf_n), 64'(e.n));
          checkOutput("buf_data", buf_data, e.data);
          checkOutput("buf_dc", 64'(buf_dc), 64'(e.dc));
          done_q.push_back(e);
        end
        acks++;
        last_ack_cycle = cycle;
      end
      if (done_a || done_b) begin
        if (done_q.size() == 0) begin
          checkOutput("unexpected_done", 64'({done_a, done_b}), 64'd0);
        end else begin
          e = done_q.pop_front();
          checkOutput("done_owner", 64'({done_a, done_b}), e.owner ? 64'd1 : 64'd2);
          checkOutput("done_err", 64'(err), 64'(e.err));
        end
        dones++;
        last_done_cycle = cycle;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int base, dbase, sbase, t;
    logic [DW-1:0] d_a1;
    d_a1 = 64'h0000_0000_0072_A0AE;
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    data_a = '0; data_b = '0; dc_a = '0; dc_b = '0; len_a = '0; len_b = '0;
    waitCycles(3);
    checkIdleOutputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] single A packet");
    @(posedge clk); #1;
    t = cycle;
    applyStimulus(1'b0, d_a1, 8'h00, 5'd3);
    waitAcks(1, 10, "t1");
    req_a = 1'b0;
    checkOutput("t1_ack_latency", 64'(last_ack_cycle), 64'(t + 1));
    waitDones(1, 200, "t1");
    checkOutput("t1_start_latency", 64'(last_start_cycle), 64'(last_ack_cycle + 1));
    checkOutput("t1_done_latency", 64'(last_done_cycle), 64'(last_final_cycle + 1));
    checkOutput("t1_no_b", 64'(ack_b_count), 64'd0);
    waitCycles(GAP_CYCLES + 4);

    $display("[TB] simultaneous A/B from reset");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    base = acks; dbase = dones;
    applyStimulus(1'b0, 64'h1111_2222_3333_4455, 8'h01, 5'd2);
    applyStimulus(1'b1, 64'h9999_8888_7777_6655, 8'h02, 5'd2);
    waitAcks(base + 1, 10, "t2a");
    req_a = 1'b0;
    waitDones(dbase + 1, 200, "t2a");
    t = last_done_cycle;
    waitAcks(base + 2, 200, "t2b");
    req_b = 1'b0;
    checkOutput("t2_gap_spacing", 64'(last_ack_cycle), 64'(t + GAP_CYCLES + 2));
    waitDones(dbase + 2, 200, "t2b");
    waitCycles(GAP_CYCLES + 4);

    $display("[TB] both held for four packets");
    base = acks; dbase = dones;
    applyStimulus(1'b0, 64'hA5A5_0000_1234_5678, 8'h0F, 5'd4);
    applyStimulus(1'b1, 64'h5A5A_FFFF_8765_4321, 8'hF0, 5'd5);
    expectPacket(1'b0, 64'hA5A5_0000_1234_5678, 8'h0F, 5'd4);
    expectPacket(1'b1, 64'h5A5A_FFFF_8765_4321, 8'hF0, 5'd5);
    waitAcks(base + 4, 1000, "t3");
    req_a = 1'b0; req_b = 1'b0;
    waitDones(dbase + 4, 300, "t3");
    checkOutput("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    waitCycles(GAP_CYCLES + 4);

    $display("[TB] zero length and clamped length");
    sbase = starts; base = acks; dbase = dones;
    applyStimulus(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h55, 5'd0);
    waitAcks(base + 1, 10, "t4b");
    req_b = 1'b0;
    waitDones(dbase + 1, 50, "t4b");
    checkOutput("t4_len0_done_latency", 64'(last_done_cycle), 64'(last_ack_cycle + 1));
    checkOutput("t4_len0_no_start", 64'(starts), 64'(sbase));
    waitCycles(GAP_CYCLES + 4);
    applyStimulus(1'b0, 64'h0102_0304_0506_0708, 8'hAA, 5'd12);
    waitAcks(base + 2, 10, "t4a");
    req_a = 1'b0;
    waitDones(dbase + 2, 200, "t4a");
    waitCycles(GAP_CYCLES + 4);

    $display("[TB] watchdog timeout");
    stub_en = 1'b0;
    model_err = 1'b1;
    base = acks; dbase = dones;
    applyStimulus(1'b0, 64'h0000_0000_0000_00C3, 8'h01, 5'd4);
    waitAcks(base + 1, 10, "t5");
    req_a = 1'b0;
    waitDones(dbase + 1, TIMEOUT + 100, "t5");
    checkOutput("t5_timeout_len", 64'(last_done_cycle), 64'(last_start_cycle + TIMEOUT + 1));
    waitCycles(GAP_CYCLES + 4);
    checkOutput("t5_err_sticky", 64'(err), 64'd1);
    checkOutput("t5_busy_after", 64'(busy), 64'd0);
    stub_en = 1'b1;
    applyStimulus(1'b1, 64'h0000_0000_0000_003C, 8'h00, 5'd1);
    waitAcks(base + 2, 10, "t5b");
    req_b = 1'b0;
    waitDones(dbase + 2, 200, "t5b");
    waitCycles(GAP_CYCLES + 4);

    $display("[TB] reset during WAIT");
    stub_en = 1'b0;
    base = acks; sbase = starts;
    applyStimulus(1'b0, 64'h0000_0000_0000_BEEF, 8'h03, 5'd2);
    waitAcks(base + 1, 10, "t6");
    req_a = 1'b0;
    waitCycles(4);
    checkOutput("t6_started", 64'(starts), 64'(sbase + 1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    model_err = 1'b0;
    checkIdleOutputs("t6_after_reset");
    stub_en = 1'b1;
    dbase = dones;
    waitCycles(20);
    checkOutput("t6_no_done", 64'(dones), 64'(dbase));
    base = acks;
    applyStimulus(1'b0, 64'h0000_0000_0000_0A0A, 8'h00, 5'd1);
    applyStimulus(1'b1, 64'h0000_0000_0000_0B0B, 8'h01, 5'd1);
    waitAcks(base + 1, 10, "t6a");
    req_a = 1'b0;
    waitAcks(base + 2, 200, "t6b");
    req_b = 1'b0;
    waitDones(dbase + 2, 200, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
